// File: rtl/dma_pkg.sv
// Shared DMA definitions: arbiter state encoding, channel count and priority modes.
// Also used by the DMA datapath.
package dma_pkg;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;

  localparam logic PRIO_FIXED  = 1'b0;
  localparam logic PRIO_ROTATE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_GRANT,
    ST_RELEASE
  } dma_state_e;

  function automatic logic [NUM_CH-1:0] ch_onehot(input logic [CH_W-1:0] ch);
    ch_onehot     = '0;
    ch_onehot[ch] = 1'b1;
  endfunction

endpackage

// File: rtl/dma_arbiter_if.sv
// Request/acknowledge bundle between the DMA channels, the CPU bus-hold logic and the arbiter.
// The arbiter connects through the slave modport.
interface dma_arbiter_if;
  import dma_pkg::*;

  logic [NUM_CH-1:0] dreq;
  logic [NUM_CH-1:0] sw_req;
  logic [NUM_CH-1:0] mask;
  logic              rotate;
  logic              hlda;
  logic              eop;
  logic              hreq;
  logic [NUM_CH-1:0] dack;
  logic              grant_valid;
  logic [CH_W-1:0]   grant_ch;
  logic              timeout_err;

  modport master (
    output dreq, sw_req, mask, rotate, hlda, eop,
    input  hreq, dack, grant_valid, grant_ch, timeout_err
  );

  modport slave (
    input  dreq, sw_req, mask, rotate, hlda, eop,
    output hreq, dack, grant_valid, grant_ch, timeout_err
  );

endinterface

// File: rtl/dma_prio_resolver.sv
// Combinational winner selection: lowest set bit of eff, scanning upward from ptr
// (rotating mode) or from channel 0 (fixed mode).
module dma_prio_resolver
  import dma_pkg::*;
(
  input  logic [NUM_CH-1:0] eff,
  input  logic [CH_W-1:0]   ptr,
  input  logic              rotate,
  output logic [CH_W-1:0]   winner,
  output logic              any
);

  logic [CH_W-1:0]     w_base;
  logic [2*NUM_CH-1:0] w_dbl;
  logic [NUM_CH-1:0]   w_rot;
  logic [CH_W-1:0]     w_off;

  // Rotate requests so the highest-priority channel lands at bit 0.
  assign w_base = (rotate == PRIO_ROTATE) ? ptr : '0;
  assign w_dbl  = {eff, eff} >> w_base;
  assign w_rot  = w_dbl[NUM_CH-1:0];

  always_comb begin
    w_off = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_off = CH_W'(i);
      end
    end
  end

  // Two-bit addition wraps modulo the channel count.
  assign winner = w_base + w_off;
  assign any    = |eff;

endmodule

// File: rtl/dma_arbiter.sv
// Four-channel DMA arbiter: picks a channel, requests the bus from the CPU (hreq/hlda),
// acknowledges the channel until eop, then waits for the CPU to take the bus back.
module dma_arbiter
  import dma_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  dma_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  dma_state_e        r_state, w_state_next;
  logic              r_hreq, w_hreq_next;
  logic [NUM_CH-1:0] r_dack, w_dack_next;
  logic              r_gv, w_gv_next;
  logic [CH_W-1:0]   r_grant_ch, w_grant_ch_next;
  logic              r_terr, w_terr_next;
  logic [CH_W-1:0]   r_ptr, w_ptr_next;
  logic [NUM_CH-1:0] r_sw_pend, w_sw_pend_next;
  logic [CNT_W-1:0]  r_cnt, w_cnt_next;
  logic              r_mode, w_mode_next;

  logic [NUM_CH-1:0] w_eff;
  logic [NUM_CH-1:0] w_sw_clr;
  logic [CH_W-1:0]   w_winner;
  logic              w_any;

  assign w_eff = (bus.dreq | r_sw_pend) & ~bus.mask;

  dma_prio_resolver u_resolver (
    .eff    (w_eff),
    .ptr    (r_ptr),
    .rotate (bus.rotate),
    .winner (w_winner),
    .any    (w_any)
  );

  always_comb begin
    w_state_next    = r_state;
    w_hreq_next     = r_hreq;
    w_dack_next     = r_dack;
    w_gv_next       = r_gv;
    w_grant_ch_next = r_grant_ch;
    w_terr_next     = r_terr;
    w_ptr_next      = r_ptr;
    w_cnt_next      = r_cnt;
    w_mode_next     = r_mode;
    w_sw_clr        = '0;

    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          // Priority mode is captured here so later toggles cannot affect this service.
          w_grant_ch_next = w_winner;
          w_mode_next     = bus.rotate;
          w_hreq_next     = 1'b1;
          w_cnt_next      = '0;
          w_state_next    = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.hlda) begin
          w_dack_next  = ch_onehot(r_grant_ch);
          w_gv_next    = 1'b1;
          w_state_next = ST_GRANT;
        end else if (!w_eff[r_grant_ch]) begin
          w_hreq_next  = 1'b0;
          w_state_next = ST_IDLE;
        end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
          w_terr_next  = 1'b1;
          w_hreq_next  = 1'b0;
          w_state_next = ST_IDLE;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      ST_GRANT: begin
        if (bus.eop) begin
          w_sw_clr = ch_onehot(r_grant_ch);
          if (r_mode == PRIO_ROTATE) begin
            w_ptr_next = r_grant_ch + 1'b1;
          end
          w_hreq_next  = 1'b0;
          w_dack_next  = '0;
          w_gv_next    = 1'b0;
          w_state_next = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (!bus.hlda) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase

    // A new software request wins over the clear from a coincident eop.
    w_sw_pend_next = (r_sw_pend & ~w_sw_clr) | bus.sw_req;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_hreq     <= 1'b0;
      r_dack     <= '0;
      r_gv       <= 1'b0;
      r_grant_ch <= '0;
      r_terr     <= 1'b0;
      r_ptr      <= '0;
      r_sw_pend  <= '0;
      r_cnt      <= '0;
      r_mode     <= PRIO_FIXED;
    end else begin
      r_state    <= w_state_next;
      r_hreq     <= w_hreq_next;
      r_dack     <= w_dack_next;
      r_gv       <= w_gv_next;
      r_grant_ch <= w_grant_ch_next;
      r_terr     <= w_terr_next;
      r_ptr      <= w_ptr_next;
      r_sw_pend  <= w_sw_pend_next;
      r_cnt      <= w_cnt_next;
      r_mode     <= w_mode_next;
    end
  end

  assign bus.hreq        = r_hreq;
  assign bus.dack        = r_dack;
  assign bus.grant_valid = r_gv;
  assign bus.grant_ch    = r_grant_ch;
  assign bus.timeout_err = r_terr;

endmodule

// File: doc/dma_arbiter.md
DMA_ARBITER -- requirements
Module: dma_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum cycles in REQ waiting for hlda before abort.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 dreq  input  4  hardware channel requests, active-high, level.
REQ-005 sw_req  input  4  software request pulses; each bit sets a pending request for its channel.
REQ-006 mask  input  4  channel mask; 1 = channel ignored.
REQ-007 rotate  input  1  priority mode: 0 = fixed (ch0 highest), 1 = rotating.
REQ-008 hlda  input  1  bus-hold acknowledge from CPU.
REQ-009 eop  input  1  end-of-service pulse from transfer sequencer for the granted channel.
REQ-010 hreq  output  1  bus-hold request to CPU.
REQ-011 dack  output  4  one-hot channel acknowledge.
REQ-012 grant_valid  output  1  granted channel owns the bus.
REQ-013 grant_ch  output  2  index of latched winner.
REQ-014 timeout_err  output  1  sticky flag: hlda timeout occurred.

Function
REQ-015 Effective request eff = (dreq | sw_pend) & ~mask, evaluated every cycle.
REQ-016 Fixed mode: winner is the lowest-index set bit of eff.
REQ-017 Rotating mode: winner is the first set bit of eff scanning from ptr upward, modulo 4.
REQ-018 After eop for channel n in rotating mode, ptr becomes (n+1) mod 4, so n becomes lowest priority; ptr is unchanged in fixed mode.
REQ-019 FSM states: IDLE, REQ, GRANT, RELEASE; all outputs are registered.
REQ-020 IDLE: if eff != 0 at a clock edge, latch the winner into grant_ch, go to REQ, and assert hreq on that edge (1-cycle latency).
REQ-021 REQ: hold hreq=1 with grant_ch frozen; no preemption by higher-priority requests.
REQ-022 REQ: hlda=1 -> GRANT, with dack[grant_ch]=1 and grant_valid=1 on the next edge.
REQ-023 REQ: if eff[grant_ch] drops while hlda=0, go to IDLE and deassert hreq on the next edge.
REQ-024 REQ: a cycle counter starting at 0 increments each cycle; at TIMEOUT with hlda=0, set timeout_err, deassert hreq, and go to IDLE.
REQ-025 GRANT: hold dack and grant_valid until eop=1; mask, dreq and rotate changes are ignored while in GRANT.
REQ-026 GRANT with eop=1: clear sw_pend[grant_ch], update ptr, and go to RELEASE with hreq, dack and grant_valid cleared on the same edge.
REQ-027 RELEASE: wait for hlda=0, then go to IDLE; no new hreq is issued before hlda falls.
REQ-028 sw_req during any state sets sw_pend on the next edge; sw_req and eop for the same channel in the same cycle leave the bit set (set wins).
REQ-029 eop outside GRANT is ignored.
REQ-030 At most one dack bit is set at any time.
REQ-031 timeout_err clears only on reset.

Reset
REQ-032 Asynchronous reset forces state=IDLE, hreq=0, dack=0, grant_valid=0, grant_ch=0, timeout_err=0, ptr=0, sw_pend=0, and counter=0.
REQ-033 Reset asserted mid-GRANT drops dack and hreq immediately (asynchronously), without waiting for eop.

Structure
REQ-034 Shared package dma_pkg holds the state enum, the channel-count constant (4), and the priority-mode constants shared with the DMA datapath.
REQ-035 A single combinational sub-module dma_prio_resolver (inputs eff, ptr, rotate; outputs winner and any) performs the winner selection.

Verification
REQ-036 Fixed mode, dreq=4'b1010, mask=0 -> hreq high 1 cycle later; hlda=1 -> dack=4'b0010, grant_ch=1.
REQ-037 Rotating mode, dreq=4'b1111 held, eop after each grant -> grants follow 0,1,2,3,0.
REQ-038 mask=4'b0001, dreq=4'b0001 -> hreq stays 0; then sw_req=4'b0100 -> channel 2 is granted after hlda.
REQ-039 TIMEOUT=8, dreq[3]=1, hlda held 0 -> hreq falls after 8 cycles in REQ and timeout_err=1.
REQ-040 In GRANT on ch2, raise dreq[0] and toggle mask -> dack remains 4'b0100 until eop; reset asserted mid-GRANT -> dack=0 and hreq=0 asynchronously.
